// File: rtl/s420_scan_ctrl_if.sv
// Signal bundle between the s420 scan sequencer and its controller/datapath.
// Master drives the scan request and Z; slave (the sequencer) drives mask, P_0 and results.
interface s420_scan_ctrl_if #(
    parameter int CYC_W = 16,
    parameter int HIT_W = 16
);
    logic             start;
    logic             abort;
    logic [CYC_W-1:0] run_len;
    logic [16:0]      cmask_in;
    logic             z_in;
    logic [16:0]      cmask_out;
    logic             p0_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [HIT_W-1:0] hit_count;
    logic             first_hit_valid;
    logic [CYC_W-1:0] first_hit_idx;

    modport master (
        output start, abort, run_len, cmask_in, z_in,
        input  cmask_out, p0_out, busy, done, aborted,
        input  hit_count, first_hit_valid, first_hit_idx
    );

    modport slave (
        input  start, abort, run_len, cmask_in, z_in,
        output cmask_out, p0_out, busy, done, aborted,
        output hit_count, first_hit_valid, first_hit_idx
    );
endinterface

// File: rtl/s420_scan_ctrl.sv
// Scan sequencer for the s420 counter/decode datapath: loads the C mask, enables P_0
// for a programmed number of cycles, and collects Z hit statistics.
//
// state | meaning
// IDLE  | waiting for start; results and mask hold
// SETUP | one cycle, mask applied, P_0 still low
// RUN   | P_0 high, Z sampled each cycle (len_r cycles)
// DRAIN | P_0 low, final Z sample after the last count step
// FIN   | done pulse, then back to IDLE
module s420_scan_ctrl #(
    parameter int CYC_W = 16,
    parameter int HIT_W = 16
) (
    input  logic                blif_clk_net,
    input  logic                blif_reset_net,
    s420_scan_ctrl_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, FIN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             sample;
    logic             abort_now;

    logic [CYC_W-1:0] len_r;
    logic [CYC_W-1:0] run_cnt;
    logic [CYC_W-1:0] idx;
    logic [16:0]      cmask_r;
    logic             p0_r;
    logic             busy_r;
    logic             done_r;
    logic             aborted_r;
    logic [HIT_W-1:0] hit_r;
    logic             fhv_r;
    logic [CYC_W-1:0] fhi_r;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sample    = 1'b0;
        abort_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (bus.abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = (len_r != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                sample = 1'b1;
                if (bus.abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else if (run_cnt == CYC_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                sample = 1'b1;
                if (bus.abort) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= IDLE;
            p0_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_q <= state_d;
            p0_r    <= (state_d == RUN);
            busy_r  <= (state_d == SETUP) || (state_d == RUN) || (state_d == DRAIN);
            done_r  <= (state_d == FIN);
        end
    end

    // run_cnt is loaded in SETUP and counts down through RUN; terminal count is 1
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            len_r     <= '0;
            run_cnt   <= '0;
            idx       <= '0;
            cmask_r   <= '0;
            aborted_r <= 1'b0;
            hit_r     <= '0;
            fhv_r     <= 1'b0;
            fhi_r     <= '0;
        end else begin
            if (accept) begin
                len_r     <= bus.run_len;
                cmask_r   <= bus.cmask_in;
                aborted_r <= 1'b0;
                hit_r     <= '0;
                fhv_r     <= 1'b0;
                fhi_r     <= '0;
                idx       <= '0;
            end
            if (state_q == SETUP) begin
                run_cnt <= len_r;
            end else if (state_q == RUN) begin
                run_cnt <= run_cnt - CYC_W'(1);
                idx     <= idx + CYC_W'(1);
            end
            if (sample && bus.z_in) begin
                if (hit_r != {HIT_W{1'b1}}) begin
                    hit_r <= hit_r + HIT_W'(1);
                end
                if (!fhv_r) begin
                    fhv_r <= 1'b1;
                    fhi_r <= idx;
                end
            end
            if (abort_now) begin
                aborted_r <= 1'b1;
            end
        end
    end

    assign bus.cmask_out       = cmask_r;
    assign bus.p0_out          = p0_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.aborted         = aborted_r;
    assign bus.hit_count       = hit_r;
    assign bus.first_hit_valid = fhv_r;
    assign bus.first_hit_idx   = fhi_r;
endmodule

// File: tb/tb_s420_scan_ctrl.sv
// Bench for s420_scan_ctrl: a cycle-offset model of a scan (SETUP at offset 1, RUN,
// DRAIN, FIN) is compared against every output each cycle, plus directed literal pins.
module tb_s420_scan_ctrl;
    localparam int CYC_W   = 16;
    localparam int HIT_W   = 3;
    localparam int HIT_MAX = (1 << HIT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    s420_scan_ctrl_if #(.CYC_W(CYC_W), .HIT_W(HIT_W)) bus ();

    s420_scan_ctrl #(.CYC_W(CYC_W), .HIT_W(HIT_W)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model: a scan is "active" from the cycle after accept through the done cycle;
    // m_t is the offset of the current cycle from the accept edge (1 = first busy cycle)
    bit          m_active;
    int          m_t;
    int          m_len;
    logic [16:0] m_mask;
    int          m_hits;
    bit          m_fhv;
    int          m_fhi;
    bit          m_aborted;

    bit          d_start;
    int          d_len;
    logic [16:0] d_mask;
    int          zmode;
    logic [63:0] z_set;
    int          abort_t;
    int          inj_t;
    logic [16:0] inj_mask;
    bit          rnd_mode;

    int acc_cyc;
    int p0_cnt;
    int done_cnt;
    int done_off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        m_active  = 0;
        m_t       = 0;
        m_len     = 0;
        m_mask    = '0;
        m_hits    = 0;
        m_fhv     = 0;
        m_fhi     = 0;
        m_aborted = 0;
    endtask

    task automatic check_outputs();
        bit e_busy, e_p0, e_done;
        e_busy = m_active && (m_t <= m_len + 2);
        e_p0   = m_active && (m_t >= 2) && (m_t <= m_len + 1);
        e_done = m_active && (m_t == m_len + 3);
        chk("busy",            32'(bus.busy),            32'(e_busy));
        chk("p0_out",          32'(bus.p0_out),          32'(e_p0));
        chk("done",            32'(bus.done),            32'(e_done));
        chk("cmask_out",       32'(bus.cmask_out),       32'(m_mask));
        chk("hit_count",       32'(bus.hit_count),       32'(m_hits));
        chk("first_hit_valid", 32'(bus.first_hit_valid), 32'(m_fhv));
        chk("first_hit_idx",   32'(bus.first_hit_idx),   32'(m_fhi));
        chk("aborted",         32'(bus.aborted),         32'(m_aborted));
        if (bus.p0_out === 1'b1) p0_cnt++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_off = cyc - 1 - acc_cyc;
        end
    endtask

    task automatic model_step(input bit st, input bit ab, input bit z,
                              input int len, input logic [16:0] mask);
        if (!m_active) begin
            if (st) begin
                m_active  = 1;
                m_t       = 1;
                m_len     = len;
                m_mask    = mask;
                m_hits    = 0;
                m_fhv     = 0;
                m_fhi     = 0;
                m_aborted = 0;
                acc_cyc   = cyc;
                p0_cnt    = 0;
                done_cnt  = 0;
                done_off  = -1;
            end
        end else begin
            if (m_t >= 2 && m_t <= m_len + 2 && z) begin
                if (m_hits < HIT_MAX) m_hits++;
                if (!m_fhv) begin
                    m_fhv = 1;
                    m_fhi = m_t - 2;
                end
            end
            if (ab && m_t <= m_len + 2) begin
                m_aborted = 1;
                m_active  = 0;
            end else if (m_t == m_len + 3) begin
                m_active = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic tick();
        int sidx;
        @(negedge clk);
        cyc++;
        check_outputs();
        sidx = (m_active && m_t >= 2 && m_t <= m_len + 2) ? m_t - 2 : -1;
        bus.start    = d_start;
        bus.run_len  = d_start ? CYC_W'(d_len) : CYC_W'($urandom);
        bus.cmask_in = d_start ? d_mask : 17'($urandom);
        bus.abort    = (abort_t != 0 && m_active && m_t == abort_t) ||
                       (rnd_mode && $urandom_range(0, 39) == 0);
        if (inj_t != 0 && m_active && m_t == inj_t) begin
            bus.start    = 1'b1;
            bus.run_len  = CYC_W'(3);
            bus.cmask_in = inj_mask;
        end
        if (rnd_mode && $urandom_range(0, 5) == 0) begin
            bus.start    = 1'b1;
            bus.run_len  = ($urandom_range(0, 9) == 0) ? CYC_W'(200) : CYC_W'($urandom_range(0, 12));
            bus.cmask_in = 17'($urandom);
        end
        case (zmode)
            1:       bus.z_in = (sidx >= 0 && sidx < 64) ? z_set[sidx] : 1'b0;
            2:       bus.z_in = 1'b1;
            default: bus.z_in = 1'($urandom_range(0, 1));
        endcase
        if (rst_n) model_step(bus.start, bus.abort, bus.z_in, int'(bus.run_len), bus.cmask_in);
    endtask

    task automatic run_scan(input int len, input logic [16:0] mask, input int zm,
                            input logic [63:0] zs, input int ab_t, input int inj);
        int n;
        zmode   = zm;
        z_set   = zs;
        abort_t = ab_t;
        inj_t   = inj;
        d_start = 1;
        d_len   = len;
        d_mask  = mask;
        tick();
        d_start = 0;
        n = 0;
        while (m_active && n < len + 20) begin
            tick();
            n++;
        end
        tick();
        abort_t = 0;
        inj_t   = 0;
    endtask

    initial begin
        int n;
        reset_model();
        d_start = 0; d_len = 0; d_mask = '0;
        zmode = 0; z_set = '0; abort_t = 0; inj_t = 0; inj_mask = 17'h0F0F0; rnd_mode = 0;
        acc_cyc = 0; p0_cnt = 0; done_cnt = 0; done_off = -1;
        bus.start = 0; bus.abort = 0; bus.run_len = '0; bus.cmask_in = '0; bus.z_in = 0;

        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("idle_cmask_lit", 32'(bus.cmask_out), 32'h0);

        // basic scan: z=1 only at sample index 1
        run_scan(5, 17'h00002, 1, 64'h2, 0, 0);
        chk("basic_p0_cycles", 32'(p0_cnt), 32'd5);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_done_off", 32'(done_off), 32'd7);
        chk("basic_hits_lit", 32'(bus.hit_count), 32'd1);
        chk("basic_fhi_lit", 32'(bus.first_hit_idx), 32'd1);
        chk("basic_cmask_lit", 32'(bus.cmask_out), 32'h00002);

        // zero length
        run_scan(0, 17'h1FFFF, 2, 64'h0, 0, 0);
        chk("zero_p0_cycles", 32'(p0_cnt), 32'd0);
        chk("zero_hits_lit", 32'(bus.hit_count), 32'd1);
        chk("zero_fhi_lit", 32'(bus.first_hit_idx), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);
        chk("zero_done_off", 32'(done_off), 32'd2);

        // saturation at 2^HIT_W-1
        run_scan(20, 17'h10001, 2, 64'h0, 0, 0);
        chk("sat_hits_lit", 32'(bus.hit_count), 32'd7);
        chk("sat_fhi_lit", 32'(bus.first_hit_idx), 32'd0);

        // abort in 10th RUN cycle (offset 11), hits on samples 3 and 9
        run_scan(100, 17'h00F00, 1, 64'h208, 11, 0);
        chk("abort_flag_lit", 32'(bus.aborted), 32'd1);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_hits_lit", 32'(bus.hit_count), 32'd2);
        chk("abort_p0_cycles", 32'(p0_cnt), 32'd10);
        run_scan(2, 17'h00003, 0, 64'h0, 0, 0);
        chk("restart_clears_aborted", 32'(bus.aborted), 32'd0);

        // start while busy is ignored
        run_scan(8, 17'h1A5A5, 0, 64'h0, 0, 4);
        chk("ign_cmask_lit", 32'(bus.cmask_out), 32'h1A5A5);
        chk("ign_p0_cycles", 32'(p0_cnt), 32'd8);
        chk("ign_done_cnt", 32'(done_cnt), 32'd1);

        // randomized traffic
        zmode = 0;
        rnd_mode = 1;
        repeat (3000) tick();
        rnd_mode = 0;
        n = 0;
        while (m_active && n < 400) begin
            tick();
            n++;
        end
        tick();

        // asynchronous reset in the middle of RUN
        zmode = 2;
        d_start = 1; d_len = 50; d_mask = 17'h0ABCD;
        tick();
        d_start = 0;
        repeat (20) tick();
        chk("pre_reset_p0", 32'(bus.p0_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p0", 32'(bus.p0_out), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_cmask", 32'(bus.cmask_out), 32'h0);
        chk("arst_hits", 32'(bus.hit_count), 32'd0);
        chk("arst_fhv", 32'(bus.first_hit_valid), 32'd0);
        reset_model();
        done_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        run_scan(3, 17'h00055, 0, 64'h0, 0, 0);
        chk("post_reset_done_cnt", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
